// File: rtl/div_sel_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_sel_ramp_ctrl_if
// Description : Request handshake bundle for div_sel_ramp_ctrl. The requester
//               (master) offers a logical divide code; the controller (slave)
//               accepts it when ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_sel_ramp_ctrl_if #(
  parameter int CODE_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_code;

  modport master (
    output req_valid,
    output req_code,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_code,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/div_sel_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_sel_ramp_ctrl
// Description : Upstream controller for the div_x_stage clock divider. Takes a
//               logical divide code over a valid/ready handshake, maps it to
//               the divider's div_sel encoding and walks div_sel toward it one
//               code per settle window, so the glitch-free switch chain never
//               sees back-to-back select changes.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sel_ramp_ctrl #(
  parameter int  STAGE_NUM  = 4,
  parameter int  SETTLE_CYC = 64,
  parameter int  STEP_MODE  = 1,
  localparam int CODE_W     = $clog2(STAGE_NUM) + 1
) (
  input  logic               clk_in,
  input  logic               rst_n,
  div_sel_ramp_ctrl_if.slave req_if,
  output logic [CODE_W-1:0]  div_sel,
  output logic [CODE_W-1:0]  cur_code,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Highest legal logical code; anything above it is rejected.
  localparam logic [CODE_W-1:0] c_max_code    = CODE_W'(STAGE_NUM);
  // Settle counter reload: counts SETTLE_CYC-1 down to 0 inclusive.
  localparam logic [15:0]       c_settle_load = 16'(SETTLE_CYC - 1);

  state_t              state_q,   state_d;
  logic [CODE_W-1:0]   cur_code_q, cur_code_d;
  logic [CODE_W-1:0]   div_sel_q,  div_sel_d;
  logic [CODE_W-1:0]   target_q,   target_d;
  logic [15:0]         cnt_q,      cnt_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;
  logic [CODE_W-1:0]   step_code;

  // Logical code r -> divider select: 0 stays bypass, k>0 becomes {1, k-1}.
  function automatic logic [CODE_W-1:0] f_map_code(input logic [CODE_W-1:0] r);
    logic [CODE_W-1:0] km1;
    km1 = r - CODE_W'(1);
    if (r == '0) begin
      return '0;
    end
    return {1'b1, km1[CODE_W-2:0]};
  endfunction

  // Next logical code taken on a STEP: one code toward target, or the target itself.
  // STEP is only entered with cur_code != target, so the ramp never overshoots.
  if (STEP_MODE != 0) begin : g_ramp
    assign step_code = (target_q > cur_code_q) ? (cur_code_q + CODE_W'(1))
                                               : (cur_code_q - CODE_W'(1));
  end else begin : g_jump
    assign step_code = target_q;
  end

  // Next-state and next-output computation for the IDLE/STEP/SETTLE controller.
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    div_sel_d  = div_sel_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_if.req_valid) begin
          if (req_if.req_code > c_max_code) begin
            err_d = 1'b1;
          end else if (req_if.req_code == cur_code_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_if.req_code;
            state_d  = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        cur_code_d = step_code;
        div_sel_d  = f_map_code(step_code);
        cnt_d      = c_settle_load;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 16'd0) begin
          if (cur_code_q == target_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STEP;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns the divider to bypass and drops any pending target.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_code_q <= '0;
      div_sel_q  <= '0;
      target_q   <= '0;
      cnt_q      <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      div_sel_q  <= div_sel_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_if.req_ready = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign div_sel          = div_sel_q;
  assign cur_code         = cur_code_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule
`default_nettype wire
